// File: rtl/pulse_measurer.sv
// Measures the delay from an accepted start to the rising edge of pulse_in and then
// that pulse's width, both in clock cycles, with timeout protection and a success counter.
module pulse_measurer #(
    parameter int RESET_DELAY = 3,
    parameter int COUNT_WIDTH = 8,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   pulse_in,
    output logic [COUNT_WIDTH-1:0] measured_delay,
    output logic [COUNT_WIDTH-1:0] measured_width,
    output logic                   measure_done,
    output logic                   measure_valid,
    output logic                   timeout_error,
    output logic [7:0]             pulse_count,
    output logic                   measurer_ready_after_reset
);

    localparam int                     RD_W      = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
    localparam logic [RD_W-1:0]        RD_LOAD   = RD_W'(RESET_DELAY - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_C = COUNT_WIDTH'(TIMEOUT);

    typedef enum logic [1:0] {
        S_RESET_DELAY,
        S_IDLE,
        S_WAIT_RISE,
        S_MEASURE_HIGH
    } state_t;

    state_t                 state, state_next;
    logic [RD_W-1:0]        rd_cnt, rd_cnt_next;
    logic [COUNT_WIDTH-1:0] delay_cnt, delay_cnt_next;
    logic [COUNT_WIDTH-1:0] width_cnt, width_cnt_next;
    logic [COUNT_WIDTH-1:0] delay_inc;
    logic [COUNT_WIDTH-1:0] measured_delay_next, measured_width_next;
    logic                   measure_done_next, measure_valid_next, timeout_error_next;
    logic [7:0]             pulse_count_next;
    logic                   ready_next;
    logic                   pulse_d;
    logic                   rise;

    always_comb begin
        state_next          = state;
        rd_cnt_next         = rd_cnt;
        delay_cnt_next      = delay_cnt;
        width_cnt_next      = width_cnt;
        measured_delay_next = measured_delay;
        measured_width_next = measured_width;
        measure_done_next   = 1'b0;
        measure_valid_next  = measure_valid;
        timeout_error_next  = timeout_error;
        pulse_count_next    = pulse_count;
        ready_next          = measurer_ready_after_reset;
        delay_inc           = delay_cnt + COUNT_WIDTH'(1);
        rise                = pulse_in & ~pulse_d;

        case (state)
            S_RESET_DELAY: begin
                if (rd_cnt != '0) begin
                    rd_cnt_next = rd_cnt - RD_W'(1);
                end else begin
                    ready_next = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    delay_cnt_next     = '0;
                    measure_valid_next = 1'b0;
                    timeout_error_next = 1'b0;
                    state_next         = S_WAIT_RISE;
                end
            end
            // A rise landing on the TIMEOUT-th edge still wins over the timeout
            S_WAIT_RISE: begin
                if (rise) begin
                    measured_delay_next = delay_inc;
                    width_cnt_next      = COUNT_WIDTH'(1);
                    state_next          = S_MEASURE_HIGH;
                end else if (delay_inc == TIMEOUT_C) begin
                    timeout_error_next = 1'b1;
                    state_next         = S_IDLE;
                end else begin
                    delay_cnt_next = delay_inc;
                end
            end
            S_MEASURE_HIGH: begin
                if (!pulse_in) begin
                    measured_width_next = width_cnt;
                    measure_valid_next  = 1'b1;
                    measure_done_next   = 1'b1;
                    pulse_count_next    = pulse_count + 8'd1;
                    state_next          = S_IDLE;
                end else if (width_cnt == TIMEOUT_C) begin
                    timeout_error_next = 1'b1;
                    state_next         = S_IDLE;
                end else begin
                    width_cnt_next = width_cnt + COUNT_WIDTH'(1);
                end
            end
            default: state_next = S_RESET_DELAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= S_RESET_DELAY;
            rd_cnt                     <= RD_LOAD;
            delay_cnt                  <= '0;
            width_cnt                  <= '0;
            measured_delay             <= '0;
            measured_width             <= '0;
            measure_done               <= 1'b0;
            measure_valid              <= 1'b0;
            timeout_error              <= 1'b0;
            pulse_count                <= 8'd0;
            measurer_ready_after_reset <= 1'b0;
            pulse_d                    <= 1'b0;
        end else begin
            state                      <= state_next;
            rd_cnt                     <= rd_cnt_next;
            delay_cnt                  <= delay_cnt_next;
            width_cnt                  <= width_cnt_next;
            measured_delay             <= measured_delay_next;
            measured_width             <= measured_width_next;
            measure_done               <= measure_done_next;
            measure_valid              <= measure_valid_next;
            timeout_error              <= timeout_error_next;
            pulse_count                <= pulse_count_next;
            measurer_ready_after_reset <= ready_next;
            pulse_d                    <= pulse_in;
        end
    end

endmodule

// File: tb/tb_pulse_measurer.sv
// Directed bench for pulse_measurer: expected outcomes are queued when each measurement
// is launched and popped when the DUT reports done or timeout.
module tb_pulse_measurer;

    localparam int RESET_DELAY = 3;
    localparam int COUNT_WIDTH = 8;
    localparam int TIMEOUT     = 10;

    logic                   clk;
    logic                   reset;
    logic                   start;
    logic                   pulse_in;
    logic [COUNT_WIDTH-1:0] measured_delay;
    logic [COUNT_WIDTH-1:0] measured_width;
    logic                   measure_done;
    logic                   measure_valid;
    logic                   timeout_error;
    logic [7:0]             pulse_count;
    logic                   measurer_ready_after_reset;

    typedef struct {
        bit         is_timeout;
        int         latency;
        logic [7:0] delay;
        logic [7:0] width;
        logic [7:0] count;
    } exp_t;

    exp_t       sb[$];
    int         tests  = 0;
    int         failed = 0;
    logic [7:0] m_delay = 8'd0;
    logic [7:0] m_width = 8'd0;
    logic [7:0] m_count = 8'd0;

    pulse_measurer #(
        .RESET_DELAY(RESET_DELAY),
        .COUNT_WIDTH(COUNT_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .start                      (start),
        .pulse_in                   (pulse_in),
        .measured_delay             (measured_delay),
        .measured_width             (measured_width),
        .measure_done               (measure_done),
        .measure_valid              (measure_valid),
        .timeout_error              (timeout_error),
        .pulse_count                (pulse_count),
        .measurer_ready_after_reset (measurer_ready_after_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
        end
    endtask

    function automatic logic level(input int k, input int d, input int w, input bit stuck, input bit prehigh);
        if (prehigh) return 1'b1;
        if (d == 0) return 1'b0;
        return (k >= d) && (stuck || k < d + w);
    endfunction

    // Outcome model: d==0 means no pulse ever appears; stuck means it never falls
    task automatic pushExpect(input int d, input int w, input bit stuck, input bit prehigh);
        exp_t e;
        if (prehigh || d == 0 || d > TIMEOUT) begin
            e.is_timeout = 1'b1;
            e.latency    = TIMEOUT;
        end else if (stuck || w > TIMEOUT) begin
            e.is_timeout = 1'b1;
            e.latency    = d + TIMEOUT;
            m_delay      = 8'(d);
        end else begin
            e.is_timeout = 1'b0;
            e.latency    = d + w;
            m_delay      = 8'(d);
            m_width      = 8'(w);
            m_count      = m_count + 8'd1;
        end
        e.delay = m_delay;
        e.width = m_width;
        e.count = m_count;
        sb.push_back(e);
    endtask

    task automatic runProfile(input int d, input int w, input bit stuck, input bit prehigh, input bit inject);
        exp_t e;
        int   lat = 0;
        for (int k = 1; k <= 2 * TIMEOUT + 4; k++) begin
            pulse_in = level(k, d, w, stuck, prehigh);
            start    = inject && (k == 2);
            tick();
            if (measure_done || timeout_error) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        e = sb.pop_front();
        checkOutput("latency",        lat,            e.latency);
        checkOutput("measure_done",   measure_done,   !e.is_timeout);
        checkOutput("timeout_error",  timeout_error,  e.is_timeout);
        checkOutput("measure_valid",  measure_valid,  !e.is_timeout);
        checkOutput("measured_delay", measured_delay, e.delay);
        checkOutput("measured_width", measured_width, e.width);
        checkOutput("pulse_count",    pulse_count,    e.count);
        pulse_in = 1'b0;
        tick();
        checkOutput("done_one_cycle", measure_done,  1'b0);
        checkOutput("valid_sticky",   measure_valid, !e.is_timeout);
    endtask

    task automatic applyStimulus(input int d, input int w, input bit stuck, input bit prehigh, input bit inject);
        pulse_in = prehigh;
        tick();
        pushExpect(d, w, stuck, prehigh);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_clears_timeout", timeout_error, 1'b0);
        checkOutput("start_clears_valid",   measure_valid, 1'b0);
        runProfile(d, w, stuck, prehigh, inject);
    endtask

    task automatic checkResetDelay();
        reset = 1'b0;
        tick();
        checkOutput("ready_edge1", measurer_ready_after_reset, 1'b0);
        tick();
        checkOutput("ready_edge2", measurer_ready_after_reset, 1'b0);
        tick();
        checkOutput("ready_edge3", measurer_ready_after_reset, 1'b1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        pulse_in = 1'b0;
        tick();
        tick();
        checkOutput("reset_outputs_zero",
                    {measured_delay, measured_width, measure_done, measure_valid,
                     timeout_error, pulse_count, measurer_ready_after_reset}, 0);

        // start held high across the reset delay: only the first IDLE edge may accept it
        checkResetDelay();
        pushExpect(0, 0, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        runProfile(0, 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(3, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, 4, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(TIMEOUT, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, TIMEOUT, 1'b0, 1'b0, 1'b0);
        applyStimulus(2, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4, 2, 1'b0, 1'b0, 1'b1);

        // Reset mid-pulse discards everything, including the success count
        pulse_in = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start    = 1'b0;
        pulse_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checkOutput("midreset_outputs_zero",
                    {measured_delay, measured_width, measure_done, measure_valid,
                     timeout_error, measurer_ready_after_reset}, 0);
        checkOutput("midreset_pulse_count", pulse_count, 8'd0);
        pulse_in = 1'b0;
        m_delay  = 8'd0;
        m_width  = 8'd0;
        m_count  = 8'd0;
        checkResetDelay();
        applyStimulus(3, 3, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
